// File: rtl/alu_decode.sv
// alu_decode: RV32I ALU-op decoder with a 2-entry output FIFO (main + skid).
//
// Decodes R-type (0110011) and I-type (0010011) instructions into an ALU
// function code plus two operands and a destination register. Anything else
// is flagged illegal with all other fields zeroed. Decoded entries are held
// in a main/skid pair so the upstream can keep streaming while the ALU
// stalls; in_ready is a flop so it never depends combinationally on
// out_ready.
//
// Optional feature: define ALU_DECODE_BYPASS_EN to forward wb_data in place
// of rs1_data (any accepted op) or rs2_data (R-type only) when the writeback
// targets the same non-zero register.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   in_valid / in_ready     instruction handshake
//   in_instr                RV32I instruction word
//   rs1_data, rs2_data      register reads for in_instr[19:15] / [24:20]
//   out_valid / out_ready   ALU handshake
//   out_func                ALU code (ZERO..SLTU = 0..10)
//   out_op1, out_op2        ALU operands
//   out_rd, out_illegal     destination register, illegal flag
//   wb_valid, wb_rd, wb_data  writeback bypass source (bypass build only)

module alu_decode #(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [DataWidth-1:0] rs1_data,
    input  logic [DataWidth-1:0] rs2_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_func,
    output logic [DataWidth-1:0] out_op1,
    output logic [DataWidth-1:0] out_op2,
    output logic [4:0]           out_rd,
    output logic                 out_illegal,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd,
    input  logic [DataWidth-1:0] wb_data
);

    // State table
    //   EMPTY | no entry buffered
    //   ONE   | main entry valid
    //   TWO   | main and skid valid, upstream stalled
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [3:0]           func;
        logic [DataWidth-1:0] op1;
        logic [DataWidth-1:0] op2;
        logic [4:0]           rd;
        logic                 illegal;
    } entry_t;

    localparam logic [3:0] F_ZERO = 4'd0,  F_ADD = 4'd1, F_SUB = 4'd2,
                           F_SLL  = 4'd3,  F_SLT = 4'd4, F_XOR = 4'd5,
                           F_OR   = 4'd6,  F_AND = 4'd7, F_SRL = 4'd8,
                           F_SRA  = 4'd9,  F_SLTU = 4'd10;

    state_t state, next_state;
    entry_t main_q, skid_q, dec;
    logic   accept, drain;
    logic   load_main, load_main_from_skid, load_skid;

    logic [DataWidth-1:0] rs1_eff, rs2_eff;

`ifdef ALU_DECODE_BYPASS_EN
    always_comb begin
        rs1_eff = rs1_data;
        rs2_eff = rs2_data;
        if (wb_valid && (wb_rd != 5'd0) && (wb_rd == in_instr[19:15]))
            rs1_eff = wb_data;
        // rs2_eff only reaches op2 on the R-type path, so the substitution
        // is effectively R-type only.
        if (wb_valid && (wb_rd != 5'd0) && (wb_rd == in_instr[24:20]))
            rs2_eff = wb_data;
    end
`else
    assign rs1_eff = rs1_data;
    assign rs2_eff = rs2_data;
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_rd, wb_data, in_instr[19:15]};
`endif

    // ---------------- decode ----------------
    logic [6:0]           opcode, funct7;
    logic [2:0]           funct3;
    logic [3:0]           func_d;
    logic [DataWidth-1:0] op2_d;
    logic                 bad;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    always_comb begin
        func_d = F_ZERO;
        op2_d  = '0;
        bad    = 1'b0;
        case (opcode)
            7'b0110011: begin
                op2_d = rs2_eff;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'd0:    func_d = F_ADD;
                        3'd1:    func_d = F_SLL;
                        3'd2:    func_d = F_SLT;
                        3'd3:    func_d = F_SLTU;
                        3'd4:    func_d = F_XOR;
                        3'd5:    func_d = F_SRL;
                        3'd6:    func_d = F_OR;
                        default: func_d = F_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
                    func_d = F_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
                    func_d = F_SRA;
                end else begin
                    bad = 1'b1;
                end
            end
            7'b0010011: begin
                op2_d = {{(DataWidth-12){in_instr[31]}}, in_instr[31:20]};
                case (funct3)
                    3'd0: func_d = F_ADD;
                    3'd1: begin
                        func_d = F_SLL;
                        op2_d  = {{(DataWidth-5){1'b0}}, in_instr[24:20]};
                        bad    = (funct7 != 7'b0000000);
                    end
                    3'd2: func_d = F_SLT;
                    3'd3: func_d = F_SLTU;
                    3'd4: func_d = F_XOR;
                    3'd5: begin
                        op2_d = {{(DataWidth-5){1'b0}}, in_instr[24:20]};
                        if (funct7 == 7'b0000000)      func_d = F_SRL;
                        else if (funct7 == 7'b0100000) func_d = F_SRA;
                        else                           bad    = 1'b1;
                    end
                    3'd6:    func_d = F_OR;
                    default: func_d = F_AND;
                endcase
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end else begin
            dec.func    = func_d;
            dec.op1     = rs1_eff;
            dec.op2     = op2_d;
            dec.rd      = in_instr[11:7];
            dec.illegal = 1'b0;
        end
    end

    // ---------------- FIFO control ----------------
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= next_state;
    end

    always_comb begin
        next_state          = state;
        load_main           = 1'b0;
        load_main_from_skid = 1'b0;
        load_skid           = 1'b0;
        case (state)
            EMPTY: if (accept) begin
                next_state = ONE;
                load_main  = 1'b1;
            end
            ONE: begin
                if (accept && drain) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    next_state = TWO;
                    load_skid  = 1'b1;
                end else if (drain) begin
                    next_state = EMPTY;
                end
            end
            TWO: if (drain) begin
                next_state          = ONE;
                load_main_from_skid = 1'b1;
            end
            default: next_state = EMPTY;
        endcase
    end

    // in_ready is looked up from the state we are about to enter so it is a
    // plain flop; reset clears it so upstream waits one edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_ready <= 1'b0;
        else        in_ready <= (next_state != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)                main_q <= dec;
            else if (load_main_from_skid) main_q <= skid_q;
            if (load_skid)                skid_q <= dec;
        end
    end

    assign out_func    = main_q.func;
    assign out_op1     = main_q.op1;
    assign out_op2     = main_q.op2;
    assign out_rd      = main_q.rd;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_decode.sv
module tb_alu_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, rs1_data, rs2_data;
    logic        out_valid, out_ready;
    logic [3:0]  out_func;
    logic [31:0] out_op1, out_op2;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    alu_decode #(.DataWidth(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_func(out_func), .out_op1(out_op1), .out_op2(out_op2),
        .out_rd(out_rd), .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    typedef struct {
        int unsigned func;
        logic [31:0] op1;
        logic [31:0] op2;
        int unsigned rd;
        bit          illegal;
    } exp_t;

    // ALU code by funct3 for the funct7=0 / plain-immediate forms
    localparam int unsigned CODE_BY_F3 [8] = '{1, 3, 4, 10, 5, 8, 6, 7};

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    bit   mdl_rdy;

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] a,
                                        input logic [31:0] b, input bit wbv,
                                        input int unsigned wbr, input logic [31:0] wbd);
        exp_t        e;
        int unsigned opc = ins[6:0];
        int unsigned f3  = ins[14:12];
        int unsigned f7  = ins[31:25];
        bit          ok  = 1;
`ifdef ALU_DECODE_BYPASS_EN
        if (wbv && wbr != 0 && wbr == int'(ins[19:15])) a = wbd;
        if (wbv && wbr != 0 && wbr == int'(ins[24:20]) && opc == 'h33) b = wbd;
`endif
        e.op1 = a;
        e.rd  = ins[11:7];
        e.illegal = 0;
        if (opc == 'h33) begin
            e.op2 = b;
            if (f7 == 0)                    e.func = CODE_BY_F3[f3];
            else if (f7 == 'h20 && f3 == 0) e.func = 2;
            else if (f7 == 'h20 && f3 == 5) e.func = 9;
            else                            ok = 0;
        end else if (opc == 'h13) begin
            e.func = CODE_BY_F3[f3];
            if (f3 == 1 || f3 == 5) begin
                e.op2 = ins[24:20];
                if (f7 == 'h20 && f3 == 5) e.func = 9;
                else if (f7 != 0)          ok = 0;
            end else begin
                e.op2 = 32'($signed(ins[31:20]));
            end
        end else begin
            ok = 0;
        end
        if (!ok) begin
            e.func = 0; e.op1 = 0; e.op2 = 0; e.rd = 0; e.illegal = 1;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".func"},    64'(out_func),    64'(e.func));
        check({tag, ".op1"},     64'(out_op1),     64'(e.op1));
        check({tag, ".op2"},     64'(out_op2),     64'(e.op2));
        check({tag, ".rd"},      64'(out_rd),      64'(e.rd));
        check({tag, ".illegal"}, 64'(out_illegal), 64'(e.illegal));
    endtask

    // Called at a negedge with inputs already driven; advances one cycle and
    // compares the DUT against the queue model at the following negedge.
    task automatic step(input string tag);
        bit   acc, drn;
        exp_t e;
        acc = in_valid && mdl_rdy;
        drn = (q.size() > 0) && out_ready;
        if (acc) e = ref_decode(in_instr, rs1_data, rs2_data, wb_valid, wb_rd, wb_data);
        @(posedge clk);
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(e);
        mdl_rdy = (q.size() < 2);
        @(negedge clk);
        check({tag, ".in_ready"},  64'(in_ready),  64'(mdl_rdy));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) check_out(tag, q[0]);
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1; in_instr = ins; rs1_data = a; rs2_data = b;
    endtask

    initial begin
        exp_t k;
        rst_n = 0; in_valid = 0; in_instr = 0; rs1_data = 0; rs2_data = 0;
        out_ready = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
        mdl_rdy = 0;
        repeat (2) @(negedge clk);
        check("rst.in_ready",  64'(in_ready),  0);
        check("rst.out_valid", 64'(out_valid), 0);
        k = '{0, 0, 0, 0, 0};
        check_out("rst", k);

        rst_n = 1;
        step("release");
        check("release.in_ready1", 64'(in_ready), 1);

        // ADD then ADDI/SRAI/illegal with out_ready high: each appears next cycle
        out_ready = 1;
        push(32'h002081B3, 5, 7);
        step("add");
        k = '{1, 5, 7, 3, 0};           check_out("add.k", k);
        push(32'hFFF00093, 0, 32'h1234);
        step("addi");
        k = '{1, 0, 32'hFFFFFFFF, 1, 0}; check_out("addi.k", k);
        push(32'h40435293, 32'h80000000, 32'h55);
        step("srai");
        k = '{9, 32'h80000000, 4, 5, 0}; check_out("srai.k", k);
        push(32'h00000000, 32'h11, 32'h22);
        step("illegal");
        k = '{0, 0, 0, 0, 1};           check_out("illegal.k", k);
        in_valid = 0;
        step("drain0");

        // backpressure: ADD then SUB held, released in order
        out_ready = 0;
        push(32'h002081B3, 5, 7);
        step("bp.add");
        push(32'h402081B3, 9, 4);
        step("bp.sub");
        check("bp.full_ready", 64'(in_ready), 0);
        check("bp.hold_add",   64'(out_func), 1);
        in_valid = 0;
        step("bp.hold");
        out_ready = 1;
        step("bp.drain1");
        check("bp.ready_back", 64'(in_ready), 1);
        check("bp.sub_func",   64'(out_func), 2);
        check("bp.sub_op1",    64'(out_op1),  9);
        step("bp.drain2");

        // reset while full
        out_ready = 0;
        push(32'h002081B3, 1, 2);
        step("rs.p1");
        push(32'h00A14233, 3, 4);
        step("rs.p2");
        #2 rst_n = 0;
        #1;
        check("rs.out_valid_now", 64'(out_valid), 0);
        check("rs.in_ready_now",  64'(in_ready),  0);
        check("rs.func_now",      64'(out_func),  0);
        q.delete();
        mdl_rdy = 0;
        @(negedge clk);
        rst_n = 1; in_valid = 0;
        step("rs.release");
        k = '{0, 0, 0, 0, 0};
        check_out("rs.zero", k);
        check("rs.in_ready", 64'(in_ready), 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int unsigned sel = $urandom_range(0, 9);
            int unsigned f7s = $urandom_range(0, 3);
            logic [6:0]  opc, f7;
            logic [2:0]  f3;
            opc = (sel < 5) ? 7'h33 : (sel < 9) ? 7'h13 : 7'($urandom);
            f7  = (f7s < 2) ? 7'h00 : (f7s == 2) ? 7'h20 : 7'($urandom);
            f3  = 3'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_instr  = {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), opc};
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            wb_valid  = $urandom_range(0, 1) == 1;
            wb_rd     = 5'($urandom_range(0, 3));
            wb_data   = $urandom;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
